// File: rtl/dispatch_pkg.sv
// Shared dispatch-side definitions: head-slot count, ready-count type and
// the wrap-around pointer adder used by the buffer and the slot mux.
package dispatch_pkg;

  localparam int READY_SLOTS = 3;

  typedef logic [1:0] ready_count_t;

  // Advance a circular pointer by inc entries, wrapping at depth.
  // Callers keep ptr < depth and inc <= depth, so a single conditional
  // subtract is enough and depth need not be a power of two.
  function automatic logic [3:0] wrap_add(input logic [3:0] ptr,
                                          input logic [3:0] inc,
                                          input logic [3:0] depth);
    logic [4:0] sum;
    sum = {1'b0, ptr} + {1'b0, inc};
    if (sum >= {1'b0, depth}) begin
      sum = sum - {1'b0, depth};
    end
    return sum[3:0];
  endfunction

endpackage

// File: rtl/ready_head_mux.sv
// Head-slot selector: presents the oldest READY_SLOTS entries of the
// circular storage in program order, zeroing slots beyond the ready count.
module ready_head_mux
  import dispatch_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0]               rd_ptr_i,
  input  logic [DEPTH*INSTR_W-1:0]       storage_i,
  input  logic [1:0]                     ready_count_i,
  output logic [READY_SLOTS*INSTR_W-1:0] slots_o
);

  logic [PTR_W-1:0] idx;

  // Slot k reads entry (rd_ptr + k) wrapped; slots at or above the count read 0.
  always_comb begin
    slots_o = '0;
    idx     = '0;
    for (int k = 0; k < READY_SLOTS; k++) begin
      idx = PTR_W'(wrap_add(4'(rd_ptr_i), 4'(k), 4'(DEPTH)));
      if (2'(k) < ready_count_i) begin
        slots_o[k*INSTR_W +: INSTR_W] = storage_i[idx*INSTR_W +: INSTR_W];
      end
    end
  end

endmodule

// File: rtl/ready_instruction_buffer.sv
// Circular buffer between decode and dispatch. Accepts one decoded word per
// cycle, exposes up to three oldest entries as ready slots, retires what the
// dispatcher consumed and empties itself on a jump flush.
module ready_instruction_buffer
  import dispatch_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                           main_clk,
  input  logic                           main_rst_n,
  input  logic                           in_valid,
  input  logic [INSTR_W-1:0]             in_instruction,
  output logic                           in_ready,
  output logic [1:0]                     ready_instruction_count_now,
  output logic [READY_SLOTS*INSTR_W-1:0] ready_instructions_extern,
  input  logic [1:0]                     used_ready_instruction_count,
  input  logic                           jump_triggering_now,
  output logic [3:0]                     occupancy
);

  localparam int         PTR_W   = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [3:0]               count_q, count_d;
  logic                     in_ready_q, in_ready_d;
  ready_count_t             rdy_cnt_q, rdy_cnt_d;
  logic [DEPTH*INSTR_W-1:0] storage_q;

  logic                     push;
  logic [1:0]               pop_n;

  // Handshake and retire amount; a flush squashes both the push and the pop.
  always_comb begin
    push  = in_valid & in_ready_q & ~jump_triggering_now;
    pop_n = 2'd0;
    if (!jump_triggering_now) begin
      pop_n = (used_ready_instruction_count > rdy_cnt_q) ? rdy_cnt_q
                                                         : used_ready_instruction_count;
    end
  end

  // Next pointers, count and the registered status it implies.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (jump_triggering_now) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = 4'd0;
    end else begin
      rd_ptr_d = PTR_W'(wrap_add(4'(rd_ptr_q), {2'b00, pop_n}, DEPTH_C));
      if (push) begin
        wr_ptr_d = PTR_W'(wrap_add(4'(wr_ptr_q), 4'd1, DEPTH_C));
      end
      count_d = count_q + {3'b000, push} - {2'b00, pop_n};
    end
    in_ready_d = (count_d < DEPTH_C);
    rdy_cnt_d  = (count_d > 4'd3) ? 2'd3 : count_d[1:0];
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= 4'd0;
      in_ready_q <= 1'b0;
      rdy_cnt_q  <= 2'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      rdy_cnt_q  <= rdy_cnt_d;
    end
  end

  // Instruction storage; contents are only visible through the masked slots, so no reset.
  always_ff @(posedge main_clk) begin
    if (push) begin
      storage_q[wr_ptr_q*INSTR_W +: INSTR_W] <= in_instruction;
    end
  end

  ready_head_mux #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W)
  ) u_head_mux (
    .rd_ptr_i      (rd_ptr_q),
    .storage_i     (storage_q),
    .ready_count_i (rdy_cnt_q),
    .slots_o       (ready_instructions_extern)
  );

  assign in_ready                    = in_ready_q;
  assign ready_instruction_count_now = rdy_cnt_q;
  assign occupancy                   = count_q;

`ifndef SYNTHESIS
  // The dispatcher may never consume more slots than were offered.
  used_within_ready : assert property (
    @(posedge main_clk) disable iff (!main_rst_n)
    !jump_triggering_now |-> (used_ready_instruction_count <= rdy_cnt_q)
  ) else $error("dispatcher used %0d slots but only %0d were ready",
                used_ready_instruction_count, rdy_cnt_q);
`endif

endmodule

// File: tb/tb_ready_instruction_buffer.sv
// Scoreboard bench for ready_instruction_buffer: a queue holds the words in
// program order, each scenario task drives cycles and compares the DUT's
// head slots, counts and handshake against it.
module tb_ready_instruction_buffer;

  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic [INSTR_W-1:0]   in_instr;
  logic                 in_ready;
  logic [1:0]           cnt_now;
  logic [3*INSTR_W-1:0] slots;
  logic [1:0]           used;
  logic                 jump;
  logic [3:0]           occupancy;

  logic [31:0] exp_q[$];
  bit          m_ready;
  int          n_checks;
  int          n_fail;

  ready_instruction_buffer #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .main_clk                     (clk),
    .main_rst_n                   (rst_n),
    .in_valid                     (in_valid),
    .in_instruction               (in_instr),
    .in_ready                     (in_ready),
    .ready_instruction_count_now  (cnt_now),
    .ready_instructions_extern    (slots),
    .used_ready_instruction_count (used),
    .jump_triggering_now          (jump),
    .occupancy                    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_cnt();
    return (exp_q.size() > 3) ? 2'd3 : 2'(exp_q.size());
  endfunction

  function automatic logic [31:0] exp_slot(input int k);
    if (k < exp_q.size()) return exp_q[k];
    return 32'h0;
  endfunction

  // Drive one cycle of stimulus, clock it, and advance the reference queue.
  task automatic clk_step(input logic v, input logic [31:0] w,
                          input logic [1:0] u, input logic j);
    int rdy;
    int popn;
    bit p;
    in_valid = v; in_instr = w; used = u; jump = j;
    rdy  = exp_q.size() > 3 ? 3 : exp_q.size();
    popn = j ? 0 : ((int'(u) > rdy) ? rdy : int'(u));
    p    = v && m_ready && !j;
    @(posedge clk); #1;
    if (j) begin
      exp_q.delete();
    end else begin
      repeat (popn) void'(exp_q.pop_front());
      if (p) exp_q.push_back(w);
    end
    m_ready  = exp_q.size() < DEPTH;
    in_valid = 1'b0; in_instr = '0; used = 2'd0; jump = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; used = 2'd0; jump = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    n_checks++; if (cnt_now !== 2'd0) begin n_fail++; $display("FAIL reset count_now: got %0d want 0", cnt_now); end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset occupancy: got %0d want 0", occupancy); end
    n_checks++; if (slots !== '0) begin n_fail++; $display("FAIL reset slots: got %h want 0", slots); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL release in_ready before edge: got %b want 0", in_ready); end
    clk_step(1'b0, 32'h0, 2'd0, 1'b0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release in_ready after edge: got %b want 1", in_ready); end
  endtask

  task automatic test_push3();
    logic [31:0] words[3] = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C};
    for (int i = 0; i < 3; i++) begin
      clk_step(1'b1, words[i], 2'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (slots[k*32 +: 32] !== exp_slot(k)) begin n_fail++; $display("FAIL push3 slot%0d: got %h want %h", k, slots[k*32 +: 32], exp_slot(k)); end
      end
      n_checks++; if (cnt_now !== 2'(i + 1)) begin n_fail++; $display("FAIL push3 count_now: got %0d want %0d", cnt_now, i + 1); end
      n_checks++; if (occupancy !== 4'(exp_q.size())) begin n_fail++; $display("FAIL push3 occupancy: got %0d want %0d", occupancy, exp_q.size()); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL push3 in_ready: got %b want 1", in_ready); end
    end
  endtask

  task automatic test_fill();
    // {valid, word, used}: push D to full, drain two, refill, push-while-full with a pop.
    logic [31:0] words[5] = '{32'hD000_000D, 32'h0, 32'hE000_000E, 32'hF000_000F, 32'h5A5A_5A5A};
    logic        vals[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0]  uses[5]  = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      clk_step(vals[i], words[i], uses[i], 1'b0);
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (slots[k*32 +: 32] !== exp_slot(k)) begin n_fail++; $display("FAIL fill step%0d slot%0d: got %h want %h", i, k, slots[k*32 +: 32], exp_slot(k)); end
      end
      n_checks++; if (cnt_now !== exp_cnt()) begin n_fail++; $display("FAIL fill step%0d count_now: got %0d want %0d", i, cnt_now, exp_cnt()); end
      n_checks++; if (occupancy !== 4'(exp_q.size())) begin n_fail++; $display("FAIL fill step%0d occupancy: got %0d want %0d", i, occupancy, exp_q.size()); end
      n_checks++; if (in_ready !== m_ready) begin n_fail++; $display("FAIL fill step%0d in_ready: got %b want %b", i, in_ready, m_ready); end
    end
    n_checks++; if (slots[0 +: 32] !== 32'hD000_000D) begin n_fail++; $display("FAIL fill full-pop slot0: got %h want d000000d", slots[0 +: 32]); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) begin
      clk_step(1'b1, 32'h1000_0000 + 32'(i), 2'd1, 1'b0);
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (slots[k*32 +: 32] !== exp_slot(k)) begin n_fail++; $display("FAIL wrap step%0d slot%0d: got %h want %h", i, k, slots[k*32 +: 32], exp_slot(k)); end
      end
      n_checks++; if (cnt_now !== exp_cnt()) begin n_fail++; $display("FAIL wrap step%0d count_now: got %0d want %0d", i, cnt_now, exp_cnt()); end
      n_checks++; if (occupancy !== 4'(exp_q.size())) begin n_fail++; $display("FAIL wrap step%0d occupancy: got %0d want %0d", i, occupancy, exp_q.size()); end
    end
  endtask

  task automatic test_jump();
    clk_step(1'b1, 32'hBAD0_0BAD, 2'd2, 1'b1);
    n_checks++; if (cnt_now !== 2'd0) begin n_fail++; $display("FAIL jump count_now: got %0d want 0", cnt_now); end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL jump occupancy: got %0d want 0", occupancy); end
    n_checks++; if (slots !== '0) begin n_fail++; $display("FAIL jump slots: got %h want 0", slots); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL jump in_ready: got %b want 1", in_ready); end
    clk_step(1'b1, 32'h7777_0001, 2'd0, 1'b0);
    n_checks++; if (slots !== {64'h0, exp_slot(0)}) begin n_fail++; $display("FAIL jump after-push slots: got %h want %h", slots, {64'h0, exp_slot(0)}); end
    n_checks++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL jump after-push occupancy: got %0d want 1", occupancy); end
  endtask

  task automatic test_back_to_back();
    clk_step(1'b1, 32'h2222_0002, 2'd0, 1'b0);
    clk_step(1'b1, 32'h3333_0003, 2'd0, 1'b0);
    clk_step(1'b1, 32'hEEEE_000E, 2'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (slots[k*32 +: 32] !== exp_slot(k)) begin n_fail++; $display("FAIL b2b slot%0d: got %h want %h", k, slots[k*32 +: 32], exp_slot(k)); end
    end
    n_checks++; if (slots[0 +: 32] !== 32'h2222_0002) begin n_fail++; $display("FAIL b2b old-slot1 in slot0: got %h want 22220002", slots[0 +: 32]); end
    n_checks++; if (slots[64 +: 32] !== 32'hEEEE_000E) begin n_fail++; $display("FAIL b2b new word in slot2: got %h want eeee000e", slots[64 +: 32]); end
    n_checks++; if (occupancy !== 4'd3) begin n_fail++; $display("FAIL b2b occupancy: got %0d want 3", occupancy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_async_reset();
    clk_step(1'b0, 32'h0, 2'd1, 1'b0);
    n_checks++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL areset pre occupancy: got %0d want 2", occupancy); end
    #2; rst_n = 1'b0; #1;
    exp_q.delete(); m_ready = 1'b0;
    n_checks++; if (cnt_now !== 2'd0) begin n_fail++; $display("FAIL areset count_now: got %0d want 0", cnt_now); end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL areset occupancy: got %0d want 0", occupancy); end
    n_checks++; if (slots !== '0) begin n_fail++; $display("FAIL areset slots: got %h want 0", slots); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL areset in_ready: got %b want 0", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    clk_step(1'b0, 32'h0, 2'd0, 1'b0);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset release in_ready: got %b want 1", in_ready); end
    clk_step(1'b1, 32'h4444_0004, 2'd0, 1'b0);
    n_checks++; if (slots !== {64'h0, 32'h4444_0004}) begin n_fail++; $display("FAIL areset resume slots: got %h want 4444_0004 in slot0", slots); end
    n_checks++; if (cnt_now !== 2'd1) begin n_fail++; $display("FAIL areset resume count_now: got %0d want 1", cnt_now); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_push3();
    test_fill();
    test_wrap();
    test_jump();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
